// File: rtl/fetch_pc_stage_pkg.sv
// Shared types and constants for the instruction-fetch PC stage.
package fetch_pc_stage_pkg;
  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, FAULT} state_e;
endpackage

// File: rtl/fetch_pc_stage_if.sv
// Fetch-stage bus: execute redirect, instruction-memory port and decode handshake.
interface fetch_pc_stage_if;
  import fetch_pc_stage_pkg::*;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            if_valid;
  logic            id_ready;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_pc_plus4;
  logic            fetch_fault;

  modport master (
    output redirect_valid, redirect_pc, imem_rvalid, imem_rdata, id_ready,
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_plus4, fetch_fault
  );

  modport slave (
    input  redirect_valid, redirect_pc, imem_rvalid, imem_rdata, id_ready,
    output imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_plus4, fetch_fault
  );
endinterface

// File: rtl/fetch_pc_stage_pc_incr.sv
// Word-granular PC incrementer; bits [1:0] pass through, the carry out of bit 31 is dropped.
module pc_incr
  import fetch_pc_stage_pkg::*;
(
  input  logic [XLEN-1:0] i_pc,
  output logic [XLEN-1:0] o_pc_plus4
);
  assign o_pc_plus4 = {i_pc[XLEN-1:2] + (XLEN-2)'(INSTR_BYTES / 4), i_pc[1:0]};
endmodule

// File: rtl/fetch_pc_stage.sv
// Fetch front end: one outstanding imem request, held instruction for decode, redirect with stale drop.
// Define PC_ALIGN_CHECK_EN to trap misaligned redirects into a sticky FAULT state.
module fetch_pc_stage
  import fetch_pc_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  fetch_pc_stage_if.slave  bus
);
  state_e          r_state, w_state;
  logic [XLEN-1:0] r_pc, w_pc, w_pc_plus4, w_redir_pc;
  logic [XLEN-1:0] r_instr, r_if_pc, r_if_pc4;
  logic            r_drop, w_drop, r_pend, w_pend, r_req, w_req;
  logic            r_valid, w_valid, r_fault, w_fault;
  logic            w_capture, w_rsp, w_misalign;

  pc_incr u_pc_incr (.i_pc(r_pc), .o_pc_plus4(w_pc_plus4));

`ifdef PC_ALIGN_CHECK_EN
  assign w_redir_pc = bus.redirect_pc;
  assign w_misalign = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
`else
  assign w_redir_pc = bus.redirect_pc & {{(XLEN-2){1'b1}}, 2'b00};
  assign w_misalign = 1'b0;
`endif

  // A response only counts once its request has left the stage.
  assign w_rsp = bus.imem_rvalid && r_pend;

  always_comb begin
    w_state   = r_state;
    w_pc      = r_pc;
    w_drop    = r_drop;
    w_req     = 1'b0;
    w_valid   = r_valid;
    w_fault   = r_fault;
    w_capture = 1'b0;
    w_pend    = r_req || (r_pend && !bus.imem_rvalid);
    case (r_state)
      IDLE: begin
        w_state = FETCH;
        w_req   = 1'b1;
      end
      FETCH: begin
        if (w_rsp && r_drop) begin
          w_drop = 1'b0;
          w_req  = 1'b1;
        end else if (w_rsp) begin
          w_capture = 1'b1;
          w_valid   = 1'b1;
          w_pc      = w_pc_plus4;
          w_state   = HOLD;
        end
      end
      HOLD: begin
        if (bus.id_ready) begin
          w_valid = 1'b0;
          w_req   = 1'b1;
          w_state = FETCH;
        end
      end
      FAULT: begin
        w_valid = 1'b0;
      end
    endcase

    // Redirect overrides everything above; an in-flight request turns into a stale one.
    if (r_state != FAULT && bus.redirect_valid) begin
      w_valid   = 1'b0;
      w_capture = 1'b0;
      if (w_misalign) begin
        w_fault = 1'b1;
        w_state = FAULT;
        w_req   = 1'b0;
        w_drop  = 1'b0;
      end else begin
        w_pc    = w_redir_pc;
        w_state = FETCH;
        if (r_state == FETCH && !w_rsp) begin
          w_drop = 1'b1;
          w_req  = 1'b0;
        end else begin
          w_drop = 1'b0;
          w_req  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_pc     <= RESET_PC;
      r_drop   <= 1'b0;
      r_pend   <= 1'b0;
      r_req    <= 1'b0;
      r_valid  <= 1'b0;
      r_fault  <= 1'b0;
      r_instr  <= '0;
      r_if_pc  <= '0;
      r_if_pc4 <= '0;
    end else begin
      r_state <= w_state;
      r_pc    <= w_pc;
      r_drop  <= w_drop;
      r_pend  <= w_pend;
      r_req   <= w_req;
      r_valid <= w_valid;
      r_fault <= w_fault;
      if (w_capture) begin
        r_instr  <= bus.imem_rdata;
        r_if_pc  <= r_pc;
        r_if_pc4 <= w_pc_plus4;
      end
    end
  end

  assign bus.imem_req    = r_req;
  assign bus.imem_addr   = r_pc;
  assign bus.if_valid    = r_valid;
  assign bus.if_instr    = r_instr;
  assign bus.if_pc       = r_if_pc;
  assign bus.if_pc_plus4 = r_if_pc4;
  assign bus.fetch_fault = r_fault;
endmodule

// File: tb/tb_fetch_pc_stage.sv
// Directed scenarios followed by a randomized run against a fetch-order reference model.
module tb_fetch_pc_stage;
  import fetch_pc_stage_pkg::*;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  fetch_pc_stage_if fif ();

  fetch_pc_stage #(.RESET_PC(RPC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (fif)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    fif.redirect_valid = 1'b0; fif.redirect_pc = '0;
    fif.imem_rvalid = 1'b0;    fif.imem_rdata = '0;
    fif.id_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({fif.imem_req, fif.if_valid, fif.fetch_fault} !== 3'b000 || fif.imem_addr !== RPC ||
        fif.if_instr !== 32'h0 || fif.if_pc !== 32'h0 || fif.if_pc_plus4 !== 32'h0) begin
      failures++;
      $display("FAIL reset: req=%b vld=%b flt=%b addr=%h instr=%h pc=%h pc4=%h, want 0 0 0 addr=%h and zeros",
               fif.imem_req, fif.if_valid, fif.fetch_fault, fif.imem_addr, fif.if_instr, fif.if_pc,
               fif.if_pc_plus4, RPC);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_hold();
    @(negedge clk);
    checks++;
    if (fif.imem_req !== 1'b1 || fif.imem_addr !== RPC) begin
      failures++;
      $display("FAIL first_req: req=%b addr=%h, want 1 %h", fif.imem_req, fif.imem_addr, RPC);
    end
    @(negedge clk);
    fif.imem_rvalid = 1'b1; fif.imem_rdata = mem_word(RPC);
    @(negedge clk);
    fif.imem_rvalid = 1'b0; fif.imem_rdata = $urandom;
    checks++;
    if (fif.if_valid !== 1'b1 || fif.if_pc !== RPC || fif.if_pc_plus4 !== RPC + 32'd4 ||
        fif.if_instr !== mem_word(RPC)) begin
      failures++;
      $display("FAIL first_present: vld=%b pc=%h pc4=%h instr=%h, want 1 %h %h %h",
               fif.if_valid, fif.if_pc, fif.if_pc_plus4, fif.if_instr, RPC, RPC + 32'd4, mem_word(RPC));
    end
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (fif.if_valid !== 1'b1 || fif.if_pc !== RPC || fif.if_instr !== mem_word(RPC) || fif.imem_req !== 1'b0) begin
        failures++;
        $display("FAIL hold_stable[%0d]: vld=%b pc=%h instr=%h req=%b, want 1 %h %h 0",
                 i, fif.if_valid, fif.if_pc, fif.if_instr, fif.imem_req, RPC, mem_word(RPC));
      end
    end
    fif.id_ready = 1'b1;
    @(negedge clk);
    fif.id_ready = 1'b0;
    checks++;
    if (fif.imem_req !== 1'b1 || fif.imem_addr !== RPC + 32'd4 || fif.if_valid !== 1'b0) begin
      failures++;
      $display("FAIL next_req: req=%b addr=%h vld=%b, want 1 %h 0", fif.imem_req, fif.imem_addr,
               fif.if_valid, RPC + 32'd4);
    end
  endtask

  // Request to 0x104 was issued this cycle; memory answers it 3 cycles later.
  task automatic test_redirect_outstanding();
    fif.redirect_valid = 1'b1; fif.redirect_pc = 32'h200;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      fif.redirect_valid = 1'b0;
      if (i == 2) begin
        fif.imem_rvalid = 1'b1; fif.imem_rdata = mem_word(32'h104);
      end
      checks++;
      if (fif.imem_req !== 1'b0 || fif.if_valid !== 1'b0 || fif.imem_addr !== 32'h200) begin
        failures++;
        $display("FAIL redir_wait[%0d]: req=%b vld=%b addr=%h, want 0 0 00000200", i, fif.imem_req,
                 fif.if_valid, fif.imem_addr);
      end
    end
    @(negedge clk);
    fif.imem_rvalid = 1'b0;
    checks++;
    if (fif.imem_req !== 1'b1 || fif.imem_addr !== 32'h200 || fif.if_valid !== 1'b0) begin
      failures++;
      $display("FAIL req_after_stale: req=%b addr=%h vld=%b, want 1 00000200 0", fif.imem_req,
               fif.imem_addr, fif.if_valid);
    end
  endtask

  task automatic test_redirect_same_cycle();
    @(negedge clk);
    fif.imem_rvalid = 1'b1; fif.imem_rdata = mem_word(32'h200);
    fif.redirect_valid = 1'b1; fif.redirect_pc = 32'h300;
    @(negedge clk);
    fif.imem_rvalid = 1'b0; fif.redirect_valid = 1'b0;
    checks++;
    if (fif.imem_req !== 1'b1 || fif.imem_addr !== 32'h300 || fif.if_valid !== 1'b0) begin
      failures++;
      $display("FAIL same_cycle_req: req=%b addr=%h vld=%b, want 1 00000300 0", fif.imem_req,
               fif.imem_addr, fif.if_valid);
    end
    @(negedge clk);
    fif.imem_rvalid = 1'b1; fif.imem_rdata = mem_word(32'h300);
    @(negedge clk);
    fif.imem_rvalid = 1'b0;
    checks++;
    if (fif.if_valid !== 1'b1 || fif.if_pc !== 32'h300 || fif.if_pc_plus4 !== 32'h304 ||
        fif.if_instr !== mem_word(32'h300)) begin
      failures++;
      $display("FAIL same_cycle_present: vld=%b pc=%h pc4=%h instr=%h, want 1 00000300 00000304 %h",
               fif.if_valid, fif.if_pc, fif.if_pc_plus4, fif.if_instr, mem_word(32'h300));
    end
  endtask

  // Redirect from HOLD discards the held word even with decode idle.
  task automatic test_wrap();
    fif.redirect_valid = 1'b1; fif.redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    fif.redirect_valid = 1'b0;
    checks++;
    if (fif.imem_req !== 1'b1 || fif.imem_addr !== 32'hFFFF_FFFC || fif.if_valid !== 1'b0) begin
      failures++;
      $display("FAIL wrap_req: req=%b addr=%h vld=%b, want 1 fffffffc 0", fif.imem_req, fif.imem_addr,
               fif.if_valid);
    end
    @(negedge clk);
    fif.imem_rvalid = 1'b1; fif.imem_rdata = mem_word(32'hFFFF_FFFC);
    @(negedge clk);
    fif.imem_rvalid = 1'b0;
    checks++;
    if (fif.if_valid !== 1'b1 || fif.if_pc !== 32'hFFFF_FFFC || fif.if_pc_plus4 !== 32'h0) begin
      failures++;
      $display("FAIL wrap_present: vld=%b pc=%h pc4=%h, want 1 fffffffc 00000000", fif.if_valid,
               fif.if_pc, fif.if_pc_plus4);
    end
    fif.id_ready = 1'b1;
    @(negedge clk);
    fif.id_ready = 1'b0;
    checks++;
    if (fif.imem_req !== 1'b1 || fif.imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL wrap_next_req: req=%b addr=%h, want 1 00000000", fif.imem_req, fif.imem_addr);
    end
  endtask

  task automatic test_misaligned();
    fif.redirect_valid = 1'b1; fif.redirect_pc = 32'h402;
    @(negedge clk);
    fif.redirect_valid = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    fif.imem_rvalid = 1'b1; fif.imem_rdata = mem_word(32'h0);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (fif.fetch_fault !== 1'b1 || fif.imem_req !== 1'b0 || fif.if_valid !== 1'b0) begin
        failures++;
        $display("FAIL fault_hold[%0d]: flt=%b req=%b vld=%b, want 1 0 0", i, fif.fetch_fault,
                 fif.imem_req, fif.if_valid);
      end
      fif.redirect_valid = (i == 2); fif.redirect_pc = 32'h500;
      fif.id_ready = 1'b1;
      @(negedge clk);
      fif.imem_rvalid = 1'b0;
    end
    fif.redirect_valid = 1'b0; fif.id_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (fif.fetch_fault !== 1'b0 || fif.imem_req !== 1'b0 || fif.if_valid !== 1'b0 || fif.imem_addr !== RPC) begin
      failures++;
      $display("FAIL fault_reset: flt=%b req=%b vld=%b addr=%h, want 0 0 0 %h", fif.fetch_fault,
               fif.imem_req, fif.if_valid, fif.imem_addr, RPC);
    end
    rst_n = 1'b1;
`else
    checks++;
    if (fif.fetch_fault !== 1'b0 || fif.imem_req !== 1'b0 || fif.imem_addr !== 32'h400) begin
      failures++;
      $display("FAIL misalign_wait: flt=%b req=%b addr=%h, want 0 0 00000400", fif.fetch_fault,
               fif.imem_req, fif.imem_addr);
    end
    fif.imem_rvalid = 1'b1; fif.imem_rdata = mem_word(32'h0);
    @(negedge clk);
    fif.imem_rvalid = 1'b0;
    checks++;
    if (fif.imem_req !== 1'b1 || fif.imem_addr !== 32'h400) begin
      failures++;
      $display("FAIL misalign_req: req=%b addr=%h, want 1 00000400", fif.imem_req, fif.imem_addr);
    end
    @(negedge clk);
    fif.imem_rvalid = 1'b1; fif.imem_rdata = mem_word(32'h400);
    @(negedge clk);
    fif.imem_rvalid = 1'b0;
    checks++;
    if (fif.if_valid !== 1'b1 || fif.if_pc !== 32'h400 || fif.if_instr !== mem_word(32'h400) ||
        fif.fetch_fault !== 1'b0) begin
      failures++;
      $display("FAIL misalign_present: vld=%b pc=%h instr=%h flt=%b, want 1 00000400 %h 0",
               fif.if_valid, fif.if_pc, fif.if_instr, fif.fetch_fault, mem_word(32'h400));
    end
`endif
  endtask

  // Model: decode must see instructions in program order from exp_pc; a redirect restarts
  // the order at its target and cancels whatever was held or in flight.
  task automatic test_random();
    logic [31:0] exp_pc, mem_addr, tgt;
    bit          busy, redir, rdy;
    int          cnt, stuck, presented;
    busy = 0; cnt = 0; stuck = 0; presented = 0; mem_addr = '0;
    fif.redirect_valid = 1'b0; fif.imem_rvalid = 1'b0; fif.id_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_pc = RPC;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (fif.if_valid) begin
        presented++;
        checks++;
        if (fif.if_pc !== exp_pc || fif.if_pc_plus4 !== exp_pc + 32'd4 || fif.if_instr !== mem_word(exp_pc) ||
            fif.imem_req !== 1'b0) begin
          failures++;
          $display("FAIL rand_present@%0d: pc=%h pc4=%h instr=%h req=%b, want %h %h %h 0", cyc, fif.if_pc,
                   fif.if_pc_plus4, fif.if_instr, fif.imem_req, exp_pc, exp_pc + 32'd4, mem_word(exp_pc));
        end
      end
      if (fif.imem_req) begin
        checks++;
        if (fif.imem_addr !== exp_pc || busy) begin
          failures++;
          $display("FAIL rand_req@%0d: addr=%h busy=%b, want %h 0", cyc, fif.imem_addr, busy, exp_pc);
        end
      end
      if (!fif.if_valid && !fif.imem_req && !busy) stuck++;
      else stuck = 0;
      if (stuck > 3) begin
        failures++;
        $display("FAIL rand_stall@%0d: no request, response or presentation for %0d cycles", cyc, stuck);
        break;
      end
      fif.imem_rvalid = 1'b0; fif.imem_rdata = $urandom;
      if (busy) begin
        cnt--;
        if (cnt == 0) begin
          fif.imem_rvalid = 1'b1; fif.imem_rdata = mem_word(mem_addr); busy = 0;
        end
      end
      if (fif.imem_req) begin
        busy = 1; cnt = $urandom_range(1, 3); mem_addr = fif.imem_addr;
      end
      redir = ($urandom_range(0, 9) == 0);
      rdy   = ($urandom_range(0, 2) != 0);
      tgt   = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hC);
      fif.redirect_valid = redir; fif.redirect_pc = tgt; fif.id_ready = rdy;
      if (redir) exp_pc = tgt;
      else if (fif.if_valid && rdy) exp_pc = exp_pc + 32'd4;
    end
    fif.redirect_valid = 1'b0; fif.id_ready = 1'b0; fif.imem_rvalid = 1'b0;
    checks++;
    if (presented < 50) begin
      failures++;
      $display("FAIL rand_progress: presented=%0d, want at least 50", presented);
    end
  endtask

  initial begin
    test_reset();
    test_basic_hold();
    test_redirect_outstanding();
    test_redirect_same_cycle();
    test_wrap();
    test_misaligned();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/fetch_pc_stage.md
# fetch_pc_stage

Instruction-fetch front end of the CPU pipeline. Holds the program counter, issues one instruction-memory request at a time, and presents the returned instruction with its PC and PC+4 to decode through a valid/ready handshake. Execute-stage branch and jump redirects override the sequential PC, and in-flight wrong-path responses are discarded.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded at reset (word aligned).
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- redirect_valid  in  1  execute requests a PC change this cycle.
- redirect_pc  in  32  target PC for the redirect.
- imem_req  out  1  one-cycle request pulse to instruction memory.
- imem_addr  out  32  request address; always equals the internal `pc` register.
- imem_rvalid  in  1  response valid; arrives 1 or more cycles after `imem_req`; at most one outstanding.
- imem_rdata  in  32  instruction word, qualified by `imem_rvalid`.
- if_valid  out  1  instruction held for decode.
- id_ready  in  1  decode accepts this cycle.
- if_instr  out  32  held instruction.
- if_pc  out  32  address of `if_instr`.
- if_pc_plus4  out  32  `if_pc + 4`, modulo 2^32.
- fetch_fault  out  1  misaligned redirect seen (sticky).

## Operation
- States: IDLE, FETCH (request outstanding), HOLD (instruction held for decode), FAULT.
- Reset values: state=IDLE, pc=RESET_PC, drop=0. All outputs are 0, except `imem_addr`, which equals RESET_PC.
- IDLE -> FETCH unconditionally; `imem_req`=1 in the first FETCH cycle.
- FETCH with `imem_rvalid` and drop=0:
  - capture `if_instr`=rdata, `if_pc`=pc, `if_pc_plus4`=pc+4;
  - set `if_valid`=1 and pc<=pc+4;
  - go to HOLD.
- FETCH with `imem_rvalid` and drop=1: discard the data, clear drop, pulse `imem_req` next cycle at the current pc, stay in FETCH.
- HOLD with `id_ready`: `if_valid`<=0, go to FETCH with `imem_req`=1 at pc. HOLD without `id_ready`: all outputs stable.
- Redirect has the highest priority in every state except FAULT. pc<=redirect_pc and `if_valid`<=0, regardless of `id_ready`. Then, by case:
  - FETCH without rvalid this cycle: drop<=1, no new request until the stale response returns.
  - FETCH with rvalid the same cycle: the data is discarded, drop stays 0, `imem_req`=1 next cycle.
  - FETCH with drop already 1: pc updates, drop stays 1.
  - IDLE or HOLD: go to FETCH with `imem_req`=1 next cycle.
- Arithmetic: `pc+4` is a 32-bit increment that wraps (32'hFFFF_FFFC -> 32'h0000_0000). There is no carry-out.
- Reset mid-operation: return immediately to the reset values. Any response arriving after reset is ignored, because a response is only accepted in FETCH after an issued request.

## Timing
- `imem_req` is registered. It is asserted the cycle after the decision that causes it.
- `imem_rvalid` -> `if_valid`: 1 cycle.
- Handshake (`if_valid`&&`id_ready`) -> next `imem_req`: 1 cycle.
- Redirect -> `imem_req` at the target: 1 cycle, or 1 cycle after the stale response returns.
- Maximum throughput is one instruction per 3 cycles with zero-wait memory. Deeper buffering is out of scope.

## Configuration
- `PC_ALIGN_CHECK_EN` defined:
  - a redirect with redirect_pc[1:0]!=0 sets `fetch_fault`=1 and goes to FAULT;
  - FAULT issues no requests, holds `if_valid`=0 and ignores further redirects until reset;
  - an outstanding response is dropped.
- Not defined: redirect_pc[1:0] is forced to 2'b00, FAULT is unreachable, and `fetch_fault` is tied to 0.

## Structure
- Shared package holds:
  - the state enum (IDLE, FETCH, HOLD, FAULT);
  - constants XLEN=32 and INSTR_BYTES=4;
  - the RESET_PC default.
- One sub-module, `pc_incr`: a combinational 32-bit +4 incrementer (carry chain on bits [31:2], bits [1:0] passed through). It is instantiated once, and its output feeds both pc and `if_pc_plus4`.

## Test plan
- Reset with RESET_PC=32'h0000_0100, memory latency 1 -> `imem_req` at 0x100, then `if_valid` with `if_pc`=0x100 and `if_pc_plus4`=0x104. The next request is at 0x104 one cycle after `id_ready`.
- `id_ready`=0 for 5 cycles while `if_valid`=1 -> `if_instr`/`if_pc` stable and no `imem_req`. Raising `id_ready` -> request at the next PC.
- Redirect to 0x200 while a request to 0x104 is outstanding (latency 3) -> the 0x104 data is never presented, and the next `imem_req` is at 0x200 the cycle after the stale rvalid.
- Redirect to 0x300 in the same cycle as rvalid -> data discarded, `imem_req` at 0x300 the next cycle, and `if_pc`=0x300 on the next presentation.
- Sequential fetch at 0xFFFF_FFFC -> `if_pc_plus4`=0x0000_0000 and the next request is at 0x0.
- With `PC_ALIGN_CHECK_EN`, redirect to 0x402 -> `fetch_fault`=1, no further requests, `if_valid`=0. rst_n low -> all cleared. Without the macro, the same redirect fetches at 0x400.
